// File: rtl/ex_stage_mdu_if.sv
// ex_stage_mdu_if: ID/EX -> EX -> EX/MEM signal bundle for the execute stage.
// master: the ID/EX side (drives operands/control, sees stall and EX/MEM).
// slave : the execute stage itself.
// Inputs : in_valid, readd1/2, forward_a/b, wb_data, mem_data, sign_ext,
//          alu_src, reg_dst, rt, rd, alu_op, funct, reg_write_in,
//          mem_read_in, mem_write_in.
// Outputs: stall, out_valid, alu_result, store_data, write_reg, ov, zero,
//          reg_write_out, mem_read_out, mem_write_out.
interface ex_stage_mdu_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int REG_DIR_WIDTH = 3
);
  logic                     in_valid;
  logic [DATA_WIDTH-1:0]    readd1, readd2, wb_data, mem_data, sign_ext;
  logic [1:0]               forward_a, forward_b;
  logic                     alu_src, reg_dst;
  logic [REG_DIR_WIDTH-1:0] rt, rd;
  logic [1:0]               alu_op;
  logic [5:0]               funct;
  logic                     reg_write_in, mem_read_in, mem_write_in;

  logic                     stall, out_valid;
  logic [DATA_WIDTH-1:0]    alu_result, store_data;
  logic [REG_DIR_WIDTH-1:0] write_reg;
  logic                     ov, zero;
  logic                     reg_write_out, mem_read_out, mem_write_out;

  modport master (
    output in_valid, readd1, readd2, wb_data, mem_data, sign_ext,
           forward_a, forward_b, alu_src, reg_dst, rt, rd, alu_op, funct,
           reg_write_in, mem_read_in, mem_write_in,
    input  stall, out_valid, alu_result, store_data, write_reg, ov, zero,
           reg_write_out, mem_read_out, mem_write_out
  );

  modport slave (
    input  in_valid, readd1, readd2, wb_data, mem_data, sign_ext,
           forward_a, forward_b, alu_src, reg_dst, rt, rd, alu_op, funct,
           reg_write_in, mem_read_in, mem_write_in,
    output stall, out_valid, alu_result, store_data, write_reg, ov, zero,
           reg_write_out, mem_read_out, mem_write_out
  );
endinterface

// File: rtl/ex_stage_mdu.sv
// ex_stage_mdu: registered MIPS execute stage. Forwarding muxes, ALU,
// ALU-control decode, destination select and EX/MEM register, plus an
// iterative (shift-add, one bit per cycle) unsigned multiplier feeding
// HI/LO and read back via mfhi/mflo.
// Ports: clk (rising edge), reset (sync, active high), bus (slave side of
// ex_stage_mdu_if carrying ID/EX inputs, stall and EX/MEM outputs).
module ex_stage_mdu #(
  parameter int DATA_WIDTH    = 8,
  parameter int REG_DIR_WIDTH = 3,
  parameter int CNT_WIDTH     = $clog2(DATA_WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  ex_stage_mdu_if.slave bus
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MULTU, OP_MFHI, OP_MFLO
  } op_e;
  typedef enum logic {IDLE, BUSY} state_e;

  state_e                   state, state_nxt;
  op_e                      op;
  logic [CNT_WIDTH-1:0]     cnt;
  logic [W-1:0]             a, b, b2, hi, lo, mcand;
  logic [W-1:0]             add_r, sub_r, res;
  logic [2*W-1:0]           prod, prod_nxt;
  logic [W:0]               psum;
  logic                     ov_add, ov_sub, is_ov;
  logic                     start, last, stall;

  // EX/MEM register
  logic                     q_valid, q_ov, q_zero, q_rw, q_mr, q_mw;
  logic [W-1:0]             q_res, q_sd;
  logic [REG_DIR_WIDTH-1:0] q_wr;

  // Forwarding muxes
  always_comb begin
    case (bus.forward_a)
      2'd0:    a = bus.readd1;
      2'd1:    a = bus.wb_data;
      2'd2:    a = bus.mem_data;
      default: a = '0;
    endcase
    case (bus.forward_b)
      2'd0:    b = bus.readd2;
      2'd1:    b = bus.wb_data;
      2'd2:    b = bus.mem_data;
      default: b = '0;
    endcase
  end
  assign b2 = bus.alu_src ? bus.sign_ext : b;

  // ALU control decode; unknown funct falls back to add
  always_comb begin
    op = OP_ADD;
    case (bus.alu_op)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b11: op = OP_OR;
      default:
        case (bus.funct)
          6'b100010: op = OP_SUB;
          6'b100100: op = OP_AND;
          6'b100101: op = OP_OR;
          6'b101010: op = OP_SLT;
          6'b011001: op = OP_MULTU;
          6'b010000: op = OP_MFHI;
          6'b010010: op = OP_MFLO;
          default:   op = OP_ADD;
        endcase
    endcase
  end

  // ALU
  assign add_r  = a + b2;
  assign sub_r  = a - b2;
  assign ov_add = (a[W-1] == b2[W-1]) && (add_r[W-1] != a[W-1]);
  assign ov_sub = (a[W-1] != b2[W-1]) && (sub_r[W-1] != a[W-1]);

  always_comb begin
    res   = '0;
    is_ov = 1'b0;
    case (op)
      OP_ADD:  begin res = add_r; is_ov = ov_add; end
      OP_SUB:  begin res = sub_r; is_ov = ov_sub; end
      OP_AND:  res = a & b2;
      OP_OR:   res = a | b2;
      // signed less-than: sign of the difference corrected for overflow
      OP_SLT:  res = {{(W-1){1'b0}}, sub_r[W-1] ^ ov_sub};
      OP_MFHI: res = hi;
      OP_MFLO: res = lo;
      default: res = '0;
    endcase
  end

  // Multiplier step: prod = {upper accumulator, remaining multiplier bits}.
  // Add the multiplicand into the upper half when the LSB is set, then
  // shift the whole thing right keeping the carry.
  assign psum     = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_nxt = {psum, prod[W-1:1]};

  assign start = (state == IDLE) && bus.in_valid && (op == OP_MULTU);
  assign last  = (state == BUSY) && (cnt == CNT_WIDTH'(W-1));

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. Stall covers the IDLE accept cycle plus W-1 busy cycles;
  // it drops on the final step so ID/EX advances as the multu retires.
  always_comb begin
    stall = 1'b0;
    if (!reset)
      stall = start || ((state == BUSY) && !last);
  end

  // Multiplier datapath and HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      prod  <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (start) begin
      mcand <= a;
      prod  <= {{W{1'b0}}, b2};
      cnt   <= '0;
    end else if (state == BUSY) begin
      prod <= prod_nxt;
      cnt  <= cnt + 1'b1;
      if (last) {hi, lo} <= prod_nxt;
    end
  end

  // EX/MEM register: normal load, multu retirement, or bubble
  always_ff @(posedge clk) begin
    if (reset || !(last || ((state == IDLE) && bus.in_valid && !start))) begin
      q_valid <= 1'b0; q_res <= '0; q_sd <= '0; q_wr <= '0;
      q_ov    <= 1'b0; q_zero <= 1'b0;
      q_rw    <= 1'b0; q_mr <= 1'b0; q_mw <= 1'b0;
    end else if (last) begin
      q_valid <= 1'b1; q_res <= '0; q_sd <= '0; q_wr <= '0;
      q_ov    <= 1'b0; q_zero <= 1'b1;
      q_rw    <= 1'b0; q_mr <= 1'b0; q_mw <= 1'b0;
    end else begin
      q_valid <= 1'b1;
      q_res   <= res;
      q_sd    <= b;
      q_wr    <= bus.reg_dst ? bus.rd : bus.rt;
      q_ov    <= is_ov;
      q_zero  <= (res == '0);
      q_rw    <= bus.reg_write_in & ~is_ov;
      q_mr    <= bus.mem_read_in;
      q_mw    <= bus.mem_write_in;
    end
  end

  assign bus.stall         = stall;
  assign bus.out_valid     = q_valid;
  assign bus.alu_result    = q_res;
  assign bus.store_data    = q_sd;
  assign bus.write_reg     = q_wr;
  assign bus.ov            = q_ov;
  assign bus.zero          = q_zero;
  assign bus.reg_write_out = q_rw;
  assign bus.mem_read_out  = q_mr;
  assign bus.mem_write_out = q_mw;
endmodule

// File: tb/tb_ex_stage_mdu.sv
// Testbench for ex_stage_mdu: table-driven vectors with a scoreboard queue,
// plus hand-written reset and multiply-abort sequences.
module tb_ex_stage_mdu;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_stage_mdu_if #(.DATA_WIDTH(W), .REG_DIR_WIDTH(3)) bus ();
  ex_stage_mdu #(.DATA_WIDTH(W), .REG_DIR_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    string      name;
    logic [1:0] fa, fb, op;
    logic [7:0] r1, r2, wb, mem, se;
    logic       src, rdst, mr, mw;
    logic [5:0] fn;
    logic [7:0] res;
    logic       eov, ez;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] res, sd;
    logic [2:0] wr;
    logic       ov, zero, rw, mr, mw, mul;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t e;
  int checks = 0, failures = 0, pushed = 0, retired = 0;

  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                         F_OR = 6'b100101, F_SLT = 6'b101010, F_MUL = 6'b011001,
                         F_HI = 6'b010000, F_LO = 6'b010010;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(string nm, logic [1:0] op, logic [5:0] fn,
                              logic [7:0] r1, logic [7:0] r2, logic [7:0] res,
                              logic eov, logic ez);
    vec_t v;
    v.name = nm; v.op = op; v.fn = fn; v.r1 = r1; v.r2 = r2;
    v.res = res; v.eov = eov; v.ez = ez;
    v.fa = 2'd0; v.fb = 2'd0; v.wb = 8'h00; v.mem = 8'h00; v.se = 8'h00;
    v.src = 1'b0; v.rdst = 1'b1; v.mr = 1'b0; v.mw = 1'b0;
    return v;
  endfunction

  // Monitor: every retirement must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_retire: got out_valid=1 required no retirement");
      end else begin
        e = sb.pop_front();
        chk({e.name, "_res"}, 16'(bus.alu_result), 16'(e.res));
        chk({e.name, "_ov"}, 16'(bus.ov), 16'(e.ov));
        chk({e.name, "_rw"}, 16'(bus.reg_write_out), 16'(e.rw));
        chk({e.name, "_mrw"}, 16'({bus.mem_read_out, bus.mem_write_out}), 16'({e.mr, e.mw}));
        if (!e.mul) begin
          chk({e.name, "_zero"}, 16'(bus.zero), 16'(e.zero));
          chk({e.name, "_wr"}, 16'(bus.write_reg), 16'(e.wr));
          chk({e.name, "_sd"}, 16'(bus.store_data), 16'(e.sd));
        end
        retired++;
      end
    end
  end

  task automatic drive(input vec_t v);
    bus.in_valid = 1'b1;
    bus.forward_a = v.fa; bus.forward_b = v.fb;
    bus.readd1 = v.r1; bus.readd2 = v.r2;
    bus.wb_data = v.wb; bus.mem_data = v.mem; bus.sign_ext = v.se;
    bus.alu_src = v.src; bus.reg_dst = v.rdst; bus.rt = 3'd2; bus.rd = 3'd5;
    bus.alu_op = v.op; bus.funct = v.fn;
    bus.reg_write_in = 1'b1; bus.mem_read_in = v.mr; bus.mem_write_in = v.mw;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic run_vec(input vec_t v, output int stalls);
    exp_t x;
    logic mul;
    mul = (v.op == 2'b10) && (v.fn == F_MUL);
    drive(v);
    x.name = v.name; x.mul = mul; x.res = v.res; x.ov = v.eov; x.zero = v.ez;
    x.rw = mul ? 1'b0 : ~v.eov;
    x.mr = mul ? 1'b0 : v.mr; x.mw = mul ? 1'b0 : v.mw;
    x.wr = v.rdst ? 3'd5 : 3'd2;
    case (v.fb)
      2'd0: x.sd = v.r2;  2'd1: x.sd = v.wb;
      2'd2: x.sd = v.mem; default: x.sd = 8'h00;
    endcase
    sb.push_back(x); pushed++;
    stalls = 0;
    @(negedge clk);
    while (bus.stall) begin
      stalls++;
      if (stalls > 1) chk({v.name, "_bubble"}, 16'(bus.out_valid), 16'd0);
      if (stalls > 40) begin
        checks++; failures++;
        $display("FAIL %s_stall_timeout: got stall>40 cycles required %0d", v.name, W);
        break;
      end
      @(posedge clk); #1;
      // operand sources move while busy; the latched operands must be used
      bus.readd1 = 8'($urandom); bus.readd2 = 8'($urandom);
      bus.wb_data = 8'($urandom); bus.mem_data = 8'($urandom);
      @(negedge clk);
    end
    chk({v.name, "_stall_len"}, 16'(stalls), mul ? 16'(W) : 16'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t v;
    int st, b2b;
    b2b = 0;
    // 0..3 basic add/sub, overflow, zero
    vecs.push_back(mk("add127", 2'b10, F_ADD, 8'd100, 8'd27, 8'd127, 0, 0));
    vecs.push_back(mk("add_ov", 2'b10, F_ADD, 8'd100, 8'd28, 8'h80, 1, 0));
    v = mk("sub_zero", 2'b01, 6'd0, 8'd5, 8'd5, 8'd0, 0, 1); v.rdst = 1'b0; vecs.push_back(v);
    vecs.push_back(mk("mul13x11", 2'b10, F_MUL, 8'd13, 8'd11, 8'd0, 0, 1));
    vecs.push_back(mk("mflo143", 2'b10, F_LO, 8'd0, 8'd0, 8'd143, 0, 0));
    vecs.push_back(mk("mfhi0", 2'b10, F_HI, 8'd0, 8'd0, 8'd0, 0, 1));
    vecs.push_back(mk("mul255", 2'b10, F_MUL, 8'd255, 8'd255, 8'd0, 0, 1));
    vecs.push_back(mk("mfhiFE", 2'b10, F_HI, 8'd0, 8'd0, 8'hFE, 0, 0));
    vecs.push_back(mk("mflo01", 2'b10, F_LO, 8'd0, 8'd0, 8'h01, 0, 0));
    v = mk("slt_fwd", 2'b10, F_SLT, 8'h55, 8'h66, 8'd0, 0, 1);
    v.fa = 2'd2; v.mem = 8'd9; v.fb = 2'd1; v.wb = 8'd3; vecs.push_back(v);
    v = mk("slt_a0", 2'b10, F_SLT, 8'h55, 8'h66, 8'd1, 0, 0);
    v.fa = 2'd3; v.fb = 2'd1; v.wb = 8'd3; vecs.push_back(v);
    v = mk("slt_imm", 2'b10, F_SLT, 8'h55, 8'h66, 8'd0, 0, 1);
    v.fa = 2'd3; v.fb = 2'd1; v.wb = 8'd3; v.src = 1'b1; v.se = 8'hFF; vecs.push_back(v);
    v = mk("and", 2'b10, F_AND, 8'hF0, 8'h3C, 8'h30, 0, 0); v.mw = 1'b1; vecs.push_back(v);
    v = mk("or_fn", 2'b10, F_OR, 8'hF0, 8'h0F, 8'hFF, 0, 0); v.mr = 1'b1; vecs.push_back(v);
    vecs.push_back(mk("or_op", 2'b11, F_ADD, 8'h12, 8'h21, 8'h33, 0, 0));
    vecs.push_back(mk("sub_ov", 2'b10, F_SUB, 8'h80, 8'h01, 8'h7F, 1, 0));
    vecs.push_back(mk("fn_dflt", 2'b10, 6'h3F, 8'd3, 8'd4, 8'd7, 0, 0));
    vecs.push_back(mk("add_ov0", 2'b00, 6'd0, 8'h80, 8'h80, 8'd0, 1, 1));
    vecs.push_back(mk("mul_b2b1", 2'b10, F_MUL, 8'd200, 8'd3, 8'd0, 0, 1));
    vecs.push_back(mk("mul_b2b2", 2'b10, F_MUL, 8'd7, 8'd9, 8'd0, 0, 1));
    vecs.push_back(mk("mfhi_b2b", 2'b10, F_HI, 8'd0, 8'd0, 8'd0, 0, 1));
    vecs.push_back(mk("mflo_b2b", 2'b10, F_LO, 8'd0, 8'd0, 8'd63, 0, 0));
    // after the reset/abort sequence
    vecs.push_back(mk("mflo_rst", 2'b10, F_LO, 8'd0, 8'd0, 8'd0, 0, 1));
    vecs.push_back(mk("mfhi_rst", 2'b10, F_HI, 8'd0, 8'd0, 8'd0, 0, 1));
    vecs.push_back(mk("add_rst", 2'b10, F_ADD, 8'd1, 8'd2, 8'd3, 0, 0));

    // Reset: stall held low even with a multu presented, outputs cleared
    reset = 1'b1;
    drive(vecs[3]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 16'(bus.stall), 16'd0);
    chk("rst_outs", 16'({bus.out_valid, bus.ov, bus.zero, bus.reg_write_out,
                         bus.mem_read_out, bus.mem_write_out}), 16'd0);
    chk("rst_data", {bus.alu_result, bus.store_data}, 16'd0);
    chk("rst_wr", 16'(bus.write_reg), 16'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 22) begin
        // Abort a multu at BUSY cnt=3 with reset; HI/LO must clear
        idle(2);
        drive(vecs[3]);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("abort_stall_during_rst", 16'(bus.stall), 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("abort_stall", 16'(bus.stall), 16'd0);
        chk("abort_outs", 16'({bus.out_valid, bus.reg_write_out, bus.ov, bus.zero}), 16'd0);
        chk("abort_res", 16'(bus.alu_result), 16'd0);
        @(posedge clk); #1;
      end
      run_vec(vecs[i], st);
      if (i == 18 || i == 19) b2b += st;
      if (i < 3 || i > 18) idle(1);
    end
    chk("b2b_stall_total", 16'(b2b), 16'(2 * W));

    idle(3);
    chk("sb_empty", 16'(sb.size()), 16'd0);
    chk("retire_count", 16'(retired), 16'(pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/ex_stage_mdu.md
Name: ex_stage_mdu

Overview:
Registered execute stage for the pipelined MIPS core; successor to the purely combinational execute logic.
- Combines the forwarding muxes, ALU, ALU-control decode, destination-register select and the EX/MEM pipeline register in one block.
- Adds an iterative unsigned multiplier writing HI/LO, plus MFHI/MFLO.
- Issues a stall to upstream stages while a multiply is in progress.

Parameters:
DATA_WIDTH, 8, operand/result width; multiply takes DATA_WIDTH iterations
REG_DIR_WIDTH, 3, register-address width
CNT_WIDTH, $clog2(DATA_WIDTH), iteration counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  ID/EX holds a real instruction
readd1, readd2  in  DATA_WIDTH  register-file operands
forward_a, forward_b  in  2  operand source select: 0 reg, 1 wb_data, 2 mem_data, 3 zero
wb_data, mem_data  in  DATA_WIDTH  forwarding sources from WB and MEM
sign_ext  in  DATA_WIDTH  immediate
alu_src  in  1  1 selects sign_ext for operand B
reg_dst  in  1  1 selects rd, 0 selects rt
rt, rd  in  REG_DIR_WIDTH  destination candidates
alu_op  in  2  00 add, 01 sub, 10 decode funct, 11 or
funct  in  6  R-type function field
reg_write_in, mem_read_in, mem_write_in  in  1  control passed to MEM
stall  out  1  hold PC, IF/ID and ID/EX
out_valid  out  1  EX/MEM holds a real instruction
alu_result  out  DATA_WIDTH  registered result
store_data  out  DATA_WIDTH  registered forwarded operand B before the alu_src mux
write_reg  out  REG_DIR_WIDTH  registered destination
ov, zero  out  1  registered signed overflow; result == 0
reg_write_out, mem_read_out, mem_write_out  out  1  registered control

Behaviour:
- Reset: every output is 0, HI = LO = 0, state is IDLE and the counter is 0. stall is forced to 0 while reset is high. A reset during a multiply aborts it; HI/LO clear.
- Operand A is selected by forward_a and operand B by forward_b (3 gives 0). B2 = alu_src ? sign_ext : B.
- With alu_op = 10, funct decodes as:
  - 100000 add
  - 100010 sub
  - 100100 and
  - 100101 or
  - 101010 slt (signed; result 1 or 0)
  - 011001 multu
  - 010000 mfhi (result = HI)
  - 010010 mflo (result = LO)
  - any other funct: add
- ov: set for signed overflow on add/sub only. When ov = 1, reg_write_out is forced to 0; alu_result still carries the wrapped sum.
- Latency: non-multiply instructions register on the next edge (1 cycle). Results wrap modulo 2^DATA_WIDTH.
- FSM states: IDLE, BUSY.
  - IDLE, with in_valid and multu decoded: stall = 1 combinationally. Latch A and B2, clear the accumulator, set cnt = 0, go to BUSY. EX/MEM loads a bubble (out_valid and all control 0).
  - BUSY: one shift-add step per cycle, 2*DATA_WIDTH-bit product.
    - cnt < DATA_WIDTH-1: stall = 1, EX/MEM loads a bubble, cnt increments.
    - cnt = DATA_WIDTH-1: stall = 0. On that edge HI/LO take the product and EX/MEM retires the multu (out_valid = 1, reg_write_out = 0, alu_result = 0). Return to IDLE.
- Stall length: stall is high for exactly DATA_WIDTH consecutive cycles per multu.
- Latched operands: ID/EX inputs may change while BUSY (forwarding sources move); the latched operands are used.
- Back-to-back instructions:
  - mfhi/mflo immediately after a multu sees the new HI/LO.
  - A multu immediately after a multu restarts from IDLE with no gap cycle.
- in_valid = 0 in IDLE: EX/MEM loads a bubble; HI/LO unchanged.
- write_reg = reg_dst ? rd : rt.
- zero is computed on the final selected result.

Test Plan:
1. W=8, alu_op=10, add, readd1=100, readd2=27 -> next edge: alu_result=127, ov=0, reg_write_out=reg_write_in, zero=0.
2. add 100+28 -> alu_result=0x80, ov=1, reg_write_out=0. sub 5-5 via alu_op=01 -> zero=1.
3. multu 13*11 -> stall high exactly 8 cycles with bubbles in EX/MEM; then mflo gives 143 and mfhi gives 0. multu 255*255 -> HI=0xFE, LO=0x01.
4. Forwarding: forward_a=2 with mem_data=9; forward_b=1 with wb_data=3; slt with readd operands ignored -> result 0. forward_a=3 -> A=0. With alu_src=1 and sign_ext=0xFF, slt 0<-1 -> 0, store_data=3.
5. Reset asserted at BUSY cnt=3 -> next cycle stall=0, state IDLE, all outputs 0, HI=LO=0; a following add executes normally.
6. Two consecutive multu, then mfhi -> 16 stall cycles total, second product visible, no lost or duplicated retirement (out_valid pulses twice).
